// File: rtl/sample_pkg.sv
// sample_pkg: shared sample width, effect-control FSM states and default ramp constants
package sample_pkg;

    localparam int SAMPLE_WIDTH       = 24;
    localparam int CTRL_WIDTH         = 17;
    localparam int DEB_CYCLES_DEF     = 1_000_000;
    localparam int RAMP_LOG2_DEF      = 8;
    localparam int SETTLE_SAMPLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SETTLE,
        FADE_IN
    } eff_state_e;

endpackage

// File: rtl/ctrl_debounce.sv
// ctrl_debounce: 2-flop synchroniser plus one shared stability counter for a control vector
module ctrl_debounce #(
    parameter int WIDTH      = 17,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] pending_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Any change of the synchronised vector restarts the count; a vector that
    // survives DEB_CYCLES unchanged cycles becomes the pending request.
    always_comb begin
        sync1_d   = raw_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        cnt_d     = (sync2_q != prev_q) ? '0 : (cnt_q == DEB_MAX) ? cnt_q : cnt_q + CW'(1);
        pending_d = (cnt_q == DEB_MAX) ? prev_q : pending_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/eff_ctrl.sv
// eff_ctrl: click-free effect switching -- fade out, apply new selection, settle muted, fade in
module eff_ctrl
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH     = SAMPLE_WIDTH,
    parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int RAMP_LOG2      = RAMP_LOG2_DEF,
    parameter int SETTLE_SAMPLES = SETTLE_SAMPLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic [15:0]                  sw_i,
    output logic [15:0]                  sel_o,
    output logic                         en_o,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         vld_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic                         busy_o
);

    localparam int GW = RAMP_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);
    localparam int PW = DATA_WIDTH + GW + 1;
    localparam logic [GW-1:0] FULL = GW'(1 << RAMP_LOG2);

    eff_state_e                  state_q, state_d;
    logic [GW-1:0]               gain_q, gain_d;
    logic [SW-1:0]               scnt_q, scnt_d;
    logic [15:0]                 sel_q, sel_d;
    logic                        en_q, en_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                        vld_q, vld_d;

    logic [CTRL_WIDTH-1:0] pending;
    logic                  change_req;
    logic [GW-1:0]         gain_dn, gain_up;
    logic signed [PW-1:0]  data_x, gain_x, prod;
    logic                  unused_ok;

    ctrl_debounce #(
        .WIDTH     (CTRL_WIDTH),
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    ({en_i, sw_i}),
        .pending_o(pending)
    );

    // Saturating one-strobe gain steps and the full-precision scaled sample
    always_comb begin
        change_req = pending != {en_q, sel_q};
        gain_dn    = (vld_i && gain_q != '0) ? gain_q - GW'(1) : gain_q;
        gain_up    = (vld_i && gain_q != FULL) ? gain_q + GW'(1) : gain_q;
        data_x     = PW'(data_i);
        gain_x     = PW'({1'b0, gain_q});
        prod       = data_x * gain_x;
        unused_ok  = ^prod;
    end

    // Next-state, gain ramp and output sample; the strobe that ends SETTLE also
    // takes the first fade-in step so exactly SETTLE_SAMPLES samples leave muted
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        scnt_d  = scnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        data_d  = vld_i ? prod[RAMP_LOG2 +: DATA_WIDTH] : data_q;
        vld_d   = vld_i;
        case (state_q)
            IDLE: begin
                gain_d = FULL;
                if (change_req) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                gain_d = gain_dn;
                if (gain_dn == '0) begin
                    state_d       = SETTLE;
                    {en_d, sel_d} = pending;
                    scnt_d        = '0;
                end
            end
            SETTLE: begin
                if (vld_i) begin
                    scnt_d = scnt_q + SW'(1);
                    if (scnt_q == SW'(SETTLE_SAMPLES - 1)) begin
                        state_d = FADE_IN;
                        gain_d  = GW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (change_req) begin
                    state_d = FADE_OUT;
                end else begin
                    gain_d = gain_up;
                    if (gain_up == FULL) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gain_q  <= FULL;
            scnt_q  <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            scnt_q  <= scnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign sel_o  = sel_q;
    assign en_o   = en_q;
    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign busy_o = state_q != IDLE;

endmodule

// File: tb/tb_eff_ctrl.sv
// tb_eff_ctrl: directed self-checking bench for eff_ctrl
module tb_eff_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_i;
    logic [15:0]        sw_i;
    logic [15:0]        sel_o;
    logic               en_o;
    logic signed [23:0] data_i;
    logic               vld_i;
    logic signed [23:0] data_o;
    logic               vld_o;
    logic               busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit saw_busy;

    eff_ctrl #(
        .DATA_WIDTH    (24),
        .DEB_CYCLES    (16),
        .RAMP_LOG2     (2),
        .SETTLE_SAMPLES(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .sw_i  (sw_i),
        .sel_o (sel_o),
        .en_o  (en_o),
        .data_i(data_i),
        .vld_i (vld_i),
        .data_o(data_o),
        .vld_o (vld_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe every 8 cycles: 7 idle cycles, then a 1-cycle vld_i
    task automatic smp(input int d);
        repeat (7) step();
        data_i = 24'(d);
        vld_i  = 1'b1;
        step();
        vld_i  = 1'b0;
    endtask

    task automatic sc(input string tag, input int d, input int exp);
        smp(d);
        chk(tag, data_o, exp);
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (busy_o !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk(tag, busy_o, 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        en_i   = 1'b0;
        sw_i   = 16'h0000;
        vld_i  = 1'b0;
        data_i = 24'sd1000;
        repeat (3) step();
        chk("rst_sel", sel_o, 0);
        chk("rst_en", en_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_busy", busy_o, 0);

        rst_n = 1'b1;
        repeat (30) step();
        chk("idle_sel", sel_o, 0);
        chk("idle_en", en_o, 0);
        chk("idle_data", data_o, 0);
        chk("idle_busy", busy_o, 0);

        // Steady-state change: enable with effect 1
        en_i = 1'b1;
        sw_i = 16'h0001;
        wait_busy("busy_on");
        chk("pre_vld_data", data_o, 0);
        sc("fo_g4", 1000, 1000);
        chk("vld_hi", vld_o, 1);
        step();
        chk("vld_lo", vld_o, 0);
        chk("data_hold", data_o, 1000);
        sc("fo_g3", 1000, 750);
        sc("fo_g2", 1000, 500);
        chk("sel_before", sel_o, 0);
        sc("fo_g1", 1000, 250);
        chk("sel_settle", sel_o, 1);
        chk("en_settle", en_o, 1);
        sc("st_0", 1000, 0);
        sc("st_1", 1000, 0);
        sc("st_2", 1000, 0);
        chk("busy_st", busy_o, 1);
        sc("fi_g1", 1000, 250);
        sc("fi_g2", 1000, 500);
        sc("fi_g3", 1000, 750);
        sc("idle_g4", 1000, 1000);
        chk("busy_done", busy_o, 0);

        // Bounce on bit 1, faster than the debounce window
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sw_i = sw_i ^ 16'h0002;
            for (int j = 0; j < 10; j++) begin
                step();
                if (busy_o) saw_busy = 1'b1;
            end
        end
        sw_i = 16'h0001;
        for (int j = 0; j < 40; j++) begin
            step();
            if (busy_o) saw_busy = 1'b1;
        end
        chk("bounce_busy", saw_busy, 0);
        chk("bounce_sel", sel_o, 16'h0001);

        // Change arriving while fading in at gain 2
        sw_i = 16'h0004;
        wait_busy("busy_on2");
        sc("c_fo_g4", 1000, 1000);
        sc("c_fo_g3", 1000, 750);
        sc("c_fo_g2", 1000, 500);
        sc("c_fo_g1", 1000, 250);
        chk("c_sel4", sel_o, 16'h0004);
        sc("c_st_0", 1000, 0);
        sc("c_st_1", 1000, 0);
        sc("c_st_2", 1000, 0);
        sc("c_fi_g1", 1000, 250);
        sw_i = 16'h0008;
        repeat (40) step();
        chk("c_stall_busy", busy_o, 1);
        chk("c_stall_sel", sel_o, 16'h0004);
        sc("c2_fo_g2", 1000, 500);
        sc("c2_fo_g1", 1000, 250);
        chk("c2_sel8", sel_o, 16'h0008);
        sc("c2_st_0", 1000, 0);
        sc("c2_st_1", 1000, 0);
        sc("c2_st_2", 1000, 0);
        sc("neg_g1", -1001, -251);
        sc("c2_fi_g2", 1000, 500);
        sc("c2_fi_g3", 1000, 750);
        chk("c2_busy_done", busy_o, 0);
        sc("c2_idle_g4", 1000, 1000);
        chk("c2_sel_final", sel_o, 16'h0008);

        // Asynchronous reset in the middle of a fade-out
        sw_i = 16'h0010;
        wait_busy("busy_on3");
        sc("r_fo_g4", 1000, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_sel", sel_o, 0);
        chk("arst_en", en_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_vld", vld_o, 0);
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_sel", sel_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eff_ctrl.md
EFF_CTRL -- requirements
Module: eff_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of the signed audio sample channel.
REQ-002 Parameter DEB_CYCLES, default 1_000_000: clock cycles a raw control input must hold stable before it is accepted.
REQ-003 Parameter RAMP_LOG2, default 8: fade length is 2^RAMP_LOG2 samples.
REQ-004 Parameter SETTLE_SAMPLES, default 64: samples held muted after a new selection is applied.
REQ-005 Port clk, input, 1: sole clock; all logic is clocked on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port en_i, input, 1: raw global effect enable, unsynchronised.
REQ-008 Port sw_i, input, 16: raw effect-select switches, unsynchronised.
REQ-009 Port sel_o, output, 16: applied effect selection, driving the pipeline select.
REQ-010 Port en_o, output, 1: applied global enable, driving the pipeline enable.
REQ-011 Port data_i, input, DATA_WIDTH: signed sample returning from the effect pipeline.
REQ-012 Port vld_i, input, 1: one-cycle strobe qualifying data_i.
REQ-013 Port data_o, output, DATA_WIDTH: gain-scaled output sample.
REQ-014 Port vld_o, output, 1: one-cycle strobe qualifying data_o.
REQ-015 Port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-016 en_i and sw_i SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 One debounce counter SHALL cover the 17-bit vector {en, sw}: the counter resets on any change of the synchronised vector, and the vector is accepted as "pending" once it has been stable for DEB_CYCLES cycles.
REQ-018 A change request SHALL exist while pending differs from the applied {en_o, sel_o}.
REQ-019 The FSM SHALL have four states: IDLE, FADE_OUT, SETTLE and FADE_IN.
REQ-020 IDLE SHALL move to FADE_OUT on a change request; gain holds at full (2^RAMP_LOG2).
REQ-021 In FADE_OUT, gain SHALL decrement by 1 on each vld_i; reaching 0 moves the FSM to SETTLE.
REQ-022 On entry to SETTLE, {en_o, sel_o} SHALL load the pending value and a sample counter SHALL clear; SETTLE_SAMPLES vld_i strobes later the FSM moves to FADE_IN.
REQ-023 In FADE_IN, gain SHALL increment by 1 on each vld_i; reaching full moves the FSM to IDLE.
REQ-024 A change request during FADE_IN SHALL move the FSM to FADE_OUT from the current gain, with no gain jump.
REQ-025 A pending change during FADE_OUT or SETTLE SHALL NOT restart the sequence; the next cycle's evaluation uses the latest pending value.
REQ-026 Gain width SHALL be RAMP_LOG2+1 bits; gain SHALL never underflow below 0 or exceed full.
REQ-027 data_o SHALL equal (data_i * gain) arithmetic-shifted right by RAMP_LOG2, truncated toward negative infinity; at full gain data_o equals data_i exactly.
REQ-028 data_o and vld_o SHALL be registered with 1-cycle latency from vld_i; data_o SHALL update only when vld_i is high.
REQ-029 The gain used for a sample SHALL be the gain value before that sample's step is applied.
REQ-030 Without vld_i strobes the FSM SHALL stall in FADE_OUT, SETTLE or FADE_IN; debouncing continues regardless.

Reset
REQ-031 While rst_n is low: state is IDLE, gain is full, sel_o=0, en_o=0, data_o=0, vld_o=0, busy_o=0, counters are 0, synchroniser and pending are 0.
REQ-032 Assertion of rst_n mid-fade SHALL take effect immediately (asynchronously); after deassertion, operation resumes from IDLE.

Structure
REQ-033 The FSM state enum and the default gain/ramp constants SHALL live in the shared sample_pkg; sample width SHALL come from sample_pkg.
REQ-034 The debouncer SHALL be a separate sub-module, ctrl_debounce, parameterised by width and DEB_CYCLES.

Verification
REQ-035 Bench SHALL use DEB_CYCLES=16, RAMP_LOG2=2 (full gain=4) and SETTLE_SAMPLES=3, with a vld_i strobe every 8 cycles and data_i=1000.
REQ-036 Scenario (reset): rst_n low, then high -> sel_o=0, en_o=0, data_o=0 and busy_o=0 until the first vld_i.
REQ-037 Scenario (steady state): en_i=1, sw_i=0x0001 -> after about 18 cycles busy_o=1; data_o sequence is 1000, 750, 500, 250, 0, 0, 0; sel_o=0x0001 and en_o=1 at SETTLE entry; then 250, 500, 750, 1000; busy_o=0.
REQ-038 Scenario (bounce): sw_i bit 1 toggles every 10 cycles for 200 cycles, then returns to its original value -> no FSM transition and sel_o unchanged.
REQ-039 Scenario (change during fade-in): sw_i changes at gain=2 in FADE_IN -> next samples are 500, 250, 0 with no jump, and the final sel_o equals the latest sw_i.
REQ-040 Scenario (negative input): data_i=-1001 at gain=1 -> data_o=-251.
REQ-041 Scenario (reset mid-fade): rst_n low during FADE_OUT -> all outputs reach their reset values without waiting for a clock edge.
